// File: rtl/mdclcg_mod_add_pipe.sv
// Two-stage pipelined modular adder: r = (a + b) mod m on a valid/ready stream.
// Stage 1 forms the raw sum and negated modulus; stage 2 resolves the compare carry.
module mdclcg_mod_add_pipe #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] r,
   output logic         wrapped,
   output logic         range_err,
   output logic [31:0]  wrap_count
);

   localparam int CW = W + 1;
   localparam int LV = $clog2(CW);
   localparam int NP = 1 << LV;

   logic          v1;
   logic          v2;
   logic [CW-1:0] s1;
   logic [CW-1:0] nm1;
   logic          err1;
   logic [W-1:0]  r2;
   logic          wr2;
   logic          err2;
   logic [31:0]   wcnt_q;

   logic          adv2;
   logic          acc;
   logic [CW-1:0] mx;
   logic [CW-1:0] sum_n;
   logic [CW-1:0] nm_n;
   logic          err_n;
   logic [NP-1:0] gv;
   logic [NP-1:0] pv;
   logic          c;
   logic [W-1:0]  t;

   assign adv2     = v1 & (~v2 | out_ready);
   assign in_ready = ~v1 | adv2;
   assign acc      = in_valid & in_ready;

   assign mx    = {1'b0, m};
   assign sum_n = {1'b0, a} + {1'b0, b};
   assign nm_n  = ~mx + CW'(1);
   assign err_n = (m != '0) & ((a >= m) | (b >= m));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         s1   <= '0;
         nm1  <= '0;
         err1 <= 1'b0;
      end else if (acc) begin
         v1   <= 1'b1;
         s1   <= sum_n;
         nm1  <= nm_n;
         err1 <= err_n;
      end else if (adv2) begin
         v1   <= 1'b0;
      end
   end

   // Carry-out of s1 + nm1 via a (g,p) reduction tree; pad groups are
   // pure propagate so they pass the lower carry through untouched.
   always_comb begin
      gv = '0;
      pv = '1;
      gv[CW-1:0] = s1 & nm1;
      pv[CW-1:0] = s1 | nm1;
      for (int k = 0; k < LV; k++) begin
         for (int j = 0; j < (NP >> (k + 1)); j++) begin
            gv[j] = gv[2*j+1] | (pv[2*j+1] & gv[2*j]);
            pv[j] = pv[2*j+1] & pv[2*j];
         end
      end
   end

   assign c = gv[0];
   assign t = s1[W-1:0] + nm1[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         r2   <= '0;
         wr2  <= 1'b0;
         err2 <= 1'b0;
      end else if (adv2) begin
         v2   <= 1'b1;
         r2   <= c ? t : s1[W-1:0];
         wr2  <= c;
         err2 <= err1;
      end else if (out_ready) begin
         v2   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
      end else if (v2 & out_ready & wr2 & ~&wcnt_q) begin
         wcnt_q <= wcnt_q + 32'd1;
      end
   end

   assign out_valid  = v2;
   assign r          = r2;
   assign wrapped    = wr2;
   assign range_err  = err2;
   assign wrap_count = wcnt_q;

endmodule

// File: tb/tb_mdclcg_mod_add_pipe.sv
// Scoreboard bench for mdclcg_mod_add_pipe: directed beats, backpressure,
// counter saturation and mid-stream reset.
module tb_mdclcg_mod_add_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic [63:0] m = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] r;
   logic        wrapped;
   logic        range_err;
   logic [31:0] wrap_count;

   mdclcg_mod_add_pipe #(.W(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .m(m),
      .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .wrapped(wrapped), .range_err(range_err),
      .wrap_count(wrap_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] r;
      logic        wr;
      logic        err;
      logic        chk_r;
      int          lat;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] exp_wc = '0;
   logic        stall_seen = 1'b0;
   logic [63:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && out_valid) begin
         if (!out_ready) begin
            if (stall_seen) chk("stall_stable", r, held);
            held = r;
            stall_seen = 1'b1;
         end else begin
            stall_seen = 1'b0;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual r=%h expected none", r);
            end else begin
               e = q.pop_front();
               if (e.chk_r) chk("r", r, e.r);
               chk("wrapped", 64'(wrapped), 64'(e.wr));
               chk("range_err", 64'(range_err), 64'(e.err));
               if (e.lat >= 0) chk("latency", 64'(cyc + 1), 64'(e.lat + 2));
               if (e.wr && exp_wc != 32'hFFFF_FFFF) exp_wc = exp_wc + 1;
            end
         end
      end else begin
         stall_seen = 1'b0;
      end
   end

   task automatic send(input logic [63:0] ia, ib, im, er,
                       input logic ew, ee, ec, input bit lat);
      int t;
      exp_t e;
      @(posedge clk);
      #1;
      a = ia;
      b = ib;
      m = im;
      in_valid = 1'b1;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual in_ready=0 expected 1");
      end else begin
         e.r = er;
         e.wr = ew;
         e.err = ee;
         e.chk_r = ec;
         e.lat = lat ? cyc + 1 : -1;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual pending=%0d expected 0", q.size());
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_r", r, 64'd0);
      chk("rst_wrap_count", 64'(wrap_count), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic, equality, extremes, m=0 and range error, back to back
      send(64'd3, 64'd4, 64'd11, 64'd7, 1'b0, 1'b0, 1'b1, 1'b1);
      send(64'd5, 64'd7, 64'd11, 64'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      send(64'd6, 64'd5, 64'd11, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
           1'b1, 1'b0, 1'b1, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
           1'b0, 1'b0, 1'b1, 1'b1);
      send(64'd12, 64'd1, 64'd11, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      send(64'd2, 64'd2, 64'd11, 64'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      drain();
      chk("wrap_count_basic", 64'(wrap_count), 64'(exp_wc));

      // Backpressure: out_ready low for cycles 2..6
      fork
         begin
            send(64'd2, 64'd3, 64'd7, 64'd5, 1'b0, 1'b0, 1'b1, 1'b0);
            send(64'd4, 64'd5, 64'd7, 64'd2, 1'b1, 1'b0, 1'b1, 1'b0);
            send(64'd6, 64'd6, 64'd7, 64'd5, 1'b1, 1'b0, 1'b1, 1'b0);
            send(64'd0, 64'd0, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle();
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("bp_in_ready_full", 64'(in_ready), 64'd0);
            chk("bp_out_valid_held", 64'(out_valid), 64'd1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("wrap_count_bp", 64'(wrap_count), 64'(exp_wc));

      // Saturation: preset the counter to all-ones, then wrap twice more
      @(negedge clk);
      force dut.wcnt_q = 32'hFFFF_FFFF;
      #1 release dut.wcnt_q;
      exp_wc = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("wrap_count_preset", 64'(wrap_count), 64'h0000_0000_FFFF_FFFF);
      send(64'd5, 64'd7, 64'd11, 64'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      send(64'd9, 64'd9, 64'd10, 64'd8, 1'b1, 1'b0, 1'b1, 1'b1);
      idle();
      drain();
      chk("wrap_count_sat", 64'(wrap_count), 64'(exp_wc));

      // Mid-stream reset with both stages full
      out_ready = 1'b0;
      send(64'd5, 64'd7, 64'd11, 64'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      send(64'd6, 64'd7, 64'd11, 64'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_wrap_count", 64'(wrap_count), 64'd0);
      q.delete();
      exp_wc = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      send(64'd1, 64'd2, 64'd5, 64'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      drain();
      chk("post_rst_wrap_count", 64'(wrap_count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
